// File: rtl/dl_rom_writer.sv
// dl_rom_writer: streams 32-bit host words into the byte-wide write ports of
// one or more download ROMs. Each accepted word becomes four byte writes at
// consecutive addresses. The top RB address bits pick which ROM region is
// enabled, so several ROMs can share one download stream.
`timescale 1ns/1ps

module dl_rom_writer #(
    parameter int AW        = 17,
    parameter int RB        = 2,
    parameter int BYTE_SWAP = 0
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                DL_START,
    input  logic                DL_END,
    input  logic                WD_VALID,
    input  logic [31:0]         WD_DATA,
    output logic                WD_READY,
    output logic [AW-1:0]       AD,
    output logic [7:0]          DO,
    output logic                WE,
    output logic [(2**RB)-1:0]  RSEL,
    output logic                BUSY,
    output logic                DONE,
    output logic                OVF
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACTIVE = 3'd1,
        S_SHIFT0 = 3'd2,
        S_SHIFT1 = 3'd3,
        S_SHIFT2 = 3'd4,
        S_SHIFT3 = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    state_t       state;
    state_t       state_nxt;

    // Address counter carries one extra bit so running past the top of the
    // download space is visible as cnt[AW] rather than wrapping to zero.
    logic [AW:0]  cnt;
    logic [31:0]  word_q;
    logic         end_pend;

    logic         issue;
    logic [1:0]   byte_idx;
    logic [31:0]  byte_src;
    logic         shift_next;

    // Byte k of the word in transmission order; BYTE_SWAP selects LSB-first.
    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] k);
        logic [1:0] j;
        j = (BYTE_SWAP != 0) ? k : (2'd3 - k);
        case (j)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    // One-hot region select from the top address bits.
    function automatic logic [(2**RB)-1:0] region_decode(input logic [RB-1:0] sel);
        logic [(2**RB)-1:0] r;
        r      = '0;
        r[sel] = 1'b1;
        return r;
    endfunction

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DL_START restarts from any state and beats DL_END.
    always_comb begin
        state_nxt = state;
        if (DL_START) begin
            state_nxt = S_ACTIVE;
        end else begin
            case (state)
                S_IDLE:   state_nxt = S_IDLE;
                S_ACTIVE: begin
                    if (WD_VALID)    state_nxt = S_SHIFT0;
                    else if (DL_END) state_nxt = S_FINISH;
                end
                S_SHIFT0: state_nxt = S_SHIFT1;
                S_SHIFT1: state_nxt = S_SHIFT2;
                S_SHIFT2: state_nxt = S_SHIFT3;
                S_SHIFT3: state_nxt = (end_pend || DL_END) ? S_FINISH : S_ACTIVE;
                S_FINISH: state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Moore status outputs decoded from the current state.
    always_comb begin
        WD_READY = 1'b0;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        case (state)
            S_ACTIVE: begin
                WD_READY = 1'b1;
                BUSY     = 1'b1;
            end
            S_SHIFT0, S_SHIFT1, S_SHIFT2, S_SHIFT3: BUSY = 1'b1;
            S_FINISH: begin
                BUSY = 1'b1;
                DONE = 1'b1;
            end
            default: ;
        endcase
    end

    // Byte issue: the handshake itself launches byte 0 straight from WD_DATA,
    // so the first write appears the cycle after the handshake; SHIFT0..2
    // launch bytes 1..3 from the latched word.
    always_comb begin
        issue    = 1'b0;
        byte_idx = 2'd0;
        byte_src = word_q;
        if (!DL_START) begin
            case (state)
                S_ACTIVE: begin
                    if (WD_VALID) begin
                        issue    = 1'b1;
                        byte_idx = 2'd0;
                        byte_src = WD_DATA;
                    end
                end
                S_SHIFT0: begin
                    issue    = 1'b1;
                    byte_idx = 2'd1;
                end
                S_SHIFT1: begin
                    issue    = 1'b1;
                    byte_idx = 2'd2;
                end
                S_SHIFT2: begin
                    issue    = 1'b1;
                    byte_idx = 2'd3;
                end
                default: ;
            endcase
        end
    end

    assign shift_next = state_nxt inside {S_SHIFT0, S_SHIFT1, S_SHIFT2, S_SHIFT3};

    // Word latch and pending-END flag; an END seen while a word is in flight
    // is held until the last byte has gone out.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            word_q   <= '0;
            end_pend <= 1'b0;
        end else begin
            if (state == S_ACTIVE && WD_VALID && !DL_START) begin
                word_q <= WD_DATA;
            end
            if (DL_START || !shift_next) begin
                end_pend <= 1'b0;
            end else begin
                end_pend <= end_pend | DL_END;
            end
        end
    end

    // Write port registers, address counter and overflow flag. Bytes past the
    // top of the space are swallowed with WE low so the host never stalls.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt  <= '0;
            AD   <= '0;
            DO   <= '0;
            WE   <= 1'b0;
            RSEL <= '0;
            OVF  <= 1'b0;
        end else if (DL_START) begin
            cnt  <= '0;
            WE   <= 1'b0;
            RSEL <= '0;
            OVF  <= 1'b0;
        end else if (issue) begin
            if (cnt[AW]) begin
                WE   <= 1'b0;
                RSEL <= '0;
                AD   <= '1;
                OVF  <= 1'b1;
            end else begin
                WE   <= 1'b1;
                AD   <= cnt[AW-1:0];
                DO   <= pick_byte(byte_src, byte_idx);
                RSEL <= region_decode(cnt[AW-1 -: RB]);
                cnt  <= cnt + {{AW{1'b0}}, 1'b1};
            end
        end else begin
            WE   <= 1'b0;
            RSEL <= '0;
        end
    end

endmodule

// File: tb/tb_dl_rom_writer.sv
// tb_dl_rom_writer: directed scoreboard bench. A small-space instance (AW=4,
// MSB-first) covers region switching and overflow; a full-size LSB-first
// instance shares the same stimulus and checks byte order.
`timescale 1ns/1ps

module tb_dl_rom_writer;

    localparam int AW  = 4;
    localparam int RB  = 2;
    localparam int AW2 = 17;

    logic        CLK      = 1'b0;
    logic        RST_N    = 1'b1;
    logic        DL_START = 1'b0;
    logic        DL_END   = 1'b0;
    logic        WD_VALID = 1'b0;
    logic [31:0] WD_DATA  = '0;

    logic           ready_m, we_m, busy_m, done_m, ovf_m;
    logic [AW-1:0]  ad_m;
    logic [7:0]     do_m;
    logic [3:0]     rsel_m;

    logic           ready_s, we_s, busy_s, done_s, ovf_s;
    logic [AW2-1:0] ad_s;
    logic [7:0]     do_s;
    logic [3:0]     rsel_s;

    dl_rom_writer #(.AW(AW), .RB(RB), .BYTE_SWAP(0)) dut (
        .CLK(CLK), .RST_N(RST_N), .DL_START(DL_START), .DL_END(DL_END),
        .WD_VALID(WD_VALID), .WD_DATA(WD_DATA), .WD_READY(ready_m),
        .AD(ad_m), .DO(do_m), .WE(we_m), .RSEL(rsel_m),
        .BUSY(busy_m), .DONE(done_m), .OVF(ovf_m)
    );

    dl_rom_writer #(.AW(AW2), .RB(RB), .BYTE_SWAP(1)) dut_swap (
        .CLK(CLK), .RST_N(RST_N), .DL_START(DL_START), .DL_END(DL_END),
        .WD_VALID(WD_VALID), .WD_DATA(WD_DATA), .WD_READY(ready_s),
        .AD(ad_s), .DO(do_s), .WE(we_s), .RSEL(rsel_s),
        .BUSY(busy_s), .DONE(done_s), .OVF(ovf_s)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [16:0] ad;
        logic [7:0]  d;
        logic [3:0]  rs;
    } wr_t;

    wr_t q_main[$];
    wr_t q_swap[$];
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected writes for the first n bytes of word w starting at address base.
    task automatic exp_word(input int base, input logic [31:0] w, input int n, input bit main_en);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.ad = 17'(base + i);
            e.d  = w[31 - 8*i -: 8];
            e.rs = 4'(1 << ((base + i) / 4));
            if (main_en) q_main.push_back(e);
            e.d  = w[8*i +: 8];
            e.rs = 4'b0001;
            q_swap.push_back(e);
        end
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge CLK);
            if (we_m) begin
                if (q_main.size() == 0) begin
                    chk("main_unexpected_we", 32'(we_m), 32'd0);
                end else begin
                    e = q_main.pop_front();
                    chk("main_ad",   32'(ad_m),   32'(e.ad));
                    chk("main_do",   32'(do_m),   32'(e.d));
                    chk("main_rsel", 32'(rsel_m), 32'(e.rs));
                end
            end else begin
                chk("main_rsel_idle", 32'(rsel_m), 32'd0);
            end
            if (we_s) begin
                if (q_swap.size() == 0) begin
                    chk("swap_unexpected_we", 32'(we_s), 32'd0);
                end else begin
                    e = q_swap.pop_front();
                    chk("swap_ad",   32'(ad_s),   32'(e.ad));
                    chk("swap_do",   32'(do_s),   32'(e.d));
                    chk("swap_rsel", 32'(rsel_s), 32'(e.rs));
                end
            end else begin
                chk("swap_rsel_idle", 32'(rsel_s), 32'd0);
            end
        end
    endtask

    task automatic pulse_start();
        DL_START = 1'b1;
        @(posedge CLK); #1;
        DL_START = 1'b0;
    endtask

    task automatic pulse_end();
        DL_END = 1'b1;
        @(posedge CLK); #1;
        DL_END = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        WD_VALID = 1'b1;
        WD_DATA  = w;
        while (!ready_m && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("send_ready_seen", 32'(ready_m), 32'd1);
        @(posedge CLK); #1;
        WD_VALID = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_m && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("wait_ready_seen", 32'(ready_m), 32'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        fork
            monitor();
        join_none

        // Reset state
        #2 RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_we",    32'(we_m),    32'd0);
        chk("rst_ad",    32'(ad_m),    32'd0);
        chk("rst_do",    32'(do_m),    32'd0);
        chk("rst_rsel",  32'(rsel_m),  32'd0);
        chk("rst_ready", 32'(ready_m), 32'd0);
        chk("rst_busy",  32'(busy_m),  32'd0);
        chk("rst_done",  32'(done_m),  32'd0);
        chk("rst_ovf",   32'(ovf_m),   32'd0);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        chk("idle_ready", 32'(ready_m), 32'd0);

        // Single word, ready low for exactly the four byte cycles
        pulse_start();
        @(negedge CLK);
        chk("t1_ready", 32'(ready_m), 32'd1);
        chk("t1_busy",  32'(busy_m),  32'd1);
        exp_word(0, 32'h11223344, 4, 1'b1);
        send_word(32'h11223344);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("t1_ready_low", 32'(ready_m), 32'd0);
        end
        @(negedge CLK);
        chk("t1_ready_high", 32'(ready_m), 32'd1);

        // Second word crosses into region 1 at address 4
        exp_word(4, 32'h55667788, 4, 1'b1);
        send_word(32'h55667788);
        wait_ready();

        // END during SHIFT1: word completes, then one-cycle DONE
        exp_word(8, 32'hAABBCCDD, 4, 1'b1);
        send_word(32'hAABBCCDD);
        @(posedge CLK); #1;
        pulse_end();
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!done_m && n < 10);
        chk("t3_done_latency", 32'(n), 32'd3);
        chk("t3_bytes_left",   32'(q_main.size()), 32'd0);
        chk("t3_busy_in_fin",  32'(busy_m), 32'd1);
        chk("t3_we_in_fin",    32'(we_m),   32'd0);
        @(negedge CLK);
        chk("t3_done_gone",  32'(done_m),  32'd0);
        chk("t3_busy_gone",  32'(busy_m),  32'd0);
        chk("t3_ready_idle", 32'(ready_m), 32'd0);

        // END while idle is ignored
        pulse_end();
        repeat (3) begin
            @(negedge CLK);
            chk("idle_end_done", 32'(done_m), 32'd0);
            chk("idle_end_busy", 32'(busy_m), 32'd0);
        end

        // Overflow with AW=4: 16 bytes fit, the fifth word is swallowed
        pulse_start();
        exp_word(0,  32'h01020304, 4, 1'b1);
        exp_word(4,  32'h05060708, 4, 1'b1);
        exp_word(8,  32'h090A0B0C, 4, 1'b1);
        exp_word(12, 32'h0D0E0F10, 4, 1'b1);
        send_word(32'h01020304);
        send_word(32'h05060708);
        send_word(32'h090A0B0C);
        send_word(32'h0D0E0F10);
        wait_ready();
        chk("t4_ovf_before", 32'(ovf_m), 32'd0);
        exp_word(16, 32'hDEADBEEF, 4, 1'b0);
        send_word(32'hDEADBEEF);
        wait_ready();
        chk("t4_ovf",      32'(ovf_m),  32'd1);
        chk("t4_ad_hold",  32'(ad_m),   32'd15);
        chk("t4_we",       32'(we_m),   32'd0);
        chk("t4_swap_ovf", 32'(ovf_s),  32'd0);
        pulse_start();
        @(negedge CLK);
        chk("t4_ovf_cleared", 32'(ovf_m), 32'd0);

        // START during SHIFT2 drops the fourth byte and rewinds the address
        exp_word(0, 32'hCAFEF00D, 3, 1'b1);
        send_word(32'hCAFEF00D);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        pulse_start();
        exp_word(0, 32'h12345678, 4, 1'b1);
        send_word(32'h12345678);
        wait_ready();
        chk("t5_bytes_left", 32'(q_main.size()), 32'd0);

        // START and END together: START wins, stays ACTIVE, no DONE
        DL_START = 1'b1;
        DL_END   = 1'b1;
        @(posedge CLK); #1;
        DL_START = 1'b0;
        DL_END   = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("t5_se_done",  32'(done_m),  32'd0);
            chk("t5_se_ready", 32'(ready_m), 32'd1);
        end

        // Asynchronous reset during SHIFT1
        exp_word(0, 32'h9ABCDEF0, 2, 1'b1);
        send_word(32'h9ABCDEF0);
        @(posedge CLK); #1;
        @(negedge CLK); #2;
        RST_N = 1'b0;
        #1;
        chk("t6_we",    32'(we_m),    32'd0);
        chk("t6_ad",    32'(ad_m),    32'd0);
        chk("t6_do",    32'(do_m),    32'd0);
        chk("t6_rsel",  32'(rsel_m),  32'd0);
        chk("t6_busy",  32'(busy_m),  32'd0);
        chk("t6_swap_we", 32'(we_s),  32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            chk("t6_post_we",    32'(we_m),    32'd0);
            chk("t6_post_ready", 32'(ready_m), 32'd0);
        end

        // Recovery after reset
        pulse_start();
        exp_word(0, 32'h0BADF00D, 4, 1'b1);
        send_word(32'h0BADF00D);
        wait_ready();

        chk("final_main_queue", 32'(q_main.size()), 32'd0);
        chk("final_swap_queue", 32'(q_swap.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
